leaf_user_stream_fifo: RTL
==========================

// Module: leaf_user_stream_fifo
// PURPOSE
//  Elastic buffer on the user side of a page's leaf_interface. Accepts 32-bit words on the
//  leaf valid/ack handshake (dout_leaf_interface2user / vld_interface2user / ack_user2interface).
//  Presents them first-word-fall-through to the HLS operator's AXI-stream input (TDATA/TVALID/TREADY).
//  Absorbs operator stalls so the leaf interface is not back-pressured each cycle.
//  Gives the page an almost-full flag.
// PARAMETERS
//  PAYLOAD_BITS   32  data word width; matches leaf_interface PAYLOAD_BITS
//  DEPTH_BITS     4   log2 of FIFO depth; DEPTH = 2**DEPTH_BITS = 16 entries
//  AFULL_THRESH   12  almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
// PORTS
//  clk            in   1              single clock for all state
//  reset          in   1              asynchronous, active-high reset
//  din            in   PAYLOAD_BITS   word from leaf_interface (dout_leaf_interface2user)
//  din_vld        in   1              din valid (vld_interface2user)
//  din_ack        out  1              FIFO can accept (ack_user2interface)
//  dout           out  PAYLOAD_BITS   head word to operator (Input_V_TDATA)
//  dout_vld       out  1              head valid (Input_V_TVALID)
//  dout_ack       in   1              operator accepts (Input_V_TREADY)
//  count          out  DEPTH_BITS+1   current occupancy, 0..DEPTH
//  almost_full    out  1              count >= AFULL_THRESH
// BEHAVIOUR
//  - Reset (async assert, sync release on clk): wr_ptr=rd_ptr=0, count=0, dout_vld=0,
//    din_ack=1 (after reset release), almost_full=0, dout=0. Contents are discarded; storage is not cleared.
//  - While reset is high, din_ack=0 and dout_vld=0.
//  - Push fires on a clk edge with din_vld && din_ack. Pop fires with dout_vld && dout_ack.
//  - din_ack  = (count != DEPTH); decoded from registered count, no comb path from dout_ack.
//  - dout_vld = (count != 0). dout = mem[rd_ptr] whenever dout_vld, 0 otherwise.
//  - Latency: word pushed at edge N is on dout with dout_vld=1 after edge N (visible cycle N+1).
//    Zero-cycle bypass is not provided.
//  - Pointers are DEPTH_BITS wide and wrap modulo DEPTH. count is tracked separately.
//  - count update: push only +1; pop only -1; push+pop same edge: unchanged, both pointers advance.
//  - Full (count==DEPTH): din_ack=0, so no push occurs even if a pop fires on the same edge.
//    din_ack rises the cycle after the pop.
//  - Empty (count==0): dout_vld=0, and dout_ack is ignored. A simultaneous push is accepted normally.
//  - Order is preserved strictly; no word is dropped or duplicated.
//  - dout_vld/dout are held stable until accepted (AXI-stream rule).
//  - almost_full is decoded combinationally from registered count and is advisory only.
//  - Reset mid-stream: all in-flight words are lost. The first push after release lands at index 0.
// CONFIGURATION
//  `define LEAF_FIFO_STATS_EN adds three output ports:
//    words_in [31:0]  total pushes
//    words_out[31:0]  total pops
//    max_count[DEPTH_BITS:0]  high-water mark of count
//  All three reset to 0. The 32-bit counters wrap 0xFFFFFFFF->0.
//  max_count updates on the edge after count exceeds it.
//  Without the macro these ports and their registers do not exist; the datapath is identical.
// TESTING
//  1 Reset release, idle: din_ack=1, dout_vld=0, count=0, almost_full=0.
//  2 Push 0xA5A5_0001: dout=0xA5A5_0001, dout_vld=1 next cycle. Pop with dout_ack=1 -> count=0.
//  3 dout_ack=0, push 16 words 0..15: count=16, din_ack=0, almost_full=1 from count=12.
//    A 17th push is not accepted; later reads return 0..15 in order.
//  4 Full FIFO, dout_ack=1 with din_vld=1: first edge pops 0 only (count=15).
//    Then steady push/pop, count stays 15, pointers wrap past 15->0 with data intact.
//  5 Empty FIFO, din_vld=1 and dout_ack=1 on the same edge: word accepted, count=1, no spurious pop.
//  6 Reset asserted with count=7 mid-stream: dout_vld=0 immediately (async), count=0.
//    After release, a push of 0x1234 is the next word out.
//    With LEAF_FIFO_STATS_EN, words_in=words_out=0 after reset and max_count=7 before it.

Source files
------------

// File: rtl/leaf_user_stream_fifo.sv
// rtl/leaf_user_stream_fifo.sv - first-word-fall-through elastic buffer between leaf_interface and an HLS stream input
//
// Purpose:
//   Words arrive on the leaf valid/ack handshake (din/din_vld/din_ack) and are
//   written into a DEPTH-entry circular buffer. The head word is presented on
//   the operator side (dout/dout_vld/dout_ack) one cycle after it was pushed.
//   Operator stalls are absorbed by the buffer, so the leaf side is only
//   back-pressured when the buffer is full.
//
// Ports:
//   clk          single clock for all state
//   reset        asynchronous, active-high reset
//   din          word from leaf_interface
//   din_vld      din valid
//   din_ack      buffer can accept a word this cycle
//   dout         head word (0 when empty)
//   dout_vld     head word valid
//   dout_ack     operator accepts the head word
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AFULL_THRESH (advisory)
//
// Optional feature, enabled by defining LEAF_FIFO_STATS_EN:
//   words_in     total pushes (wraps)
//   words_out    total pops (wraps)
//   max_count    high-water mark of count

module leaf_user_stream_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic [DEPTH_BITS:0]     count,
`ifdef LEAF_FIFO_STATS_EN
    output logic [31:0]             words_in,
    output logic [31:0]             words_out,
    output logic [DEPTH_BITS:0]     max_count,
`endif
    output logic                    almost_full
);

    localparam int                  DEPTH       = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT  = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] AFULL_COUNT = (DEPTH_BITS+1)'(AFULL_THRESH);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic [DEPTH_BITS:0]     count_r;
    logic                    running;
    logic                    push;
    logic                    pop;

    // running is cleared asynchronously by reset and set on the first clock
    // edge after release, so din_ack is low for the whole reset period and
    // rises synchronously without reset itself appearing in the datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // Handshake decodes come only from registered state: no combinational
    // path from dout_ack to din_ack. A full buffer refuses a push even when a
    // pop fires on the same edge; din_ack rises the cycle after the pop.
    assign din_ack     = running && (count_r != FULL_COUNT);
    assign dout_vld    = (count_r != '0);
    assign push        = din_vld && din_ack;
    assign pop         = dout_vld && dout_ack;
    assign count       = count_r;
    assign almost_full = (count_r >= AFULL_COUNT);
    assign dout        = dout_vld ? mem[rd_ptr] : '0;

    // Storage is not reset; stale contents are never visible because dout
    // is forced to 0 whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef LEAF_FIFO_STATS_EN
    logic [31:0]         words_in_r;
    logic [31:0]         words_out_r;
    logic [DEPTH_BITS:0] max_count_r;

    // max_count follows count one edge later, since it compares against the
    // registered occupancy rather than the next-state value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_in_r  <= '0;
            words_out_r <= '0;
            max_count_r <= '0;
        end else begin
            if (push) begin
                words_in_r <= words_in_r + 32'd1;
            end
            if (pop) begin
                words_out_r <= words_out_r + 32'd1;
            end
            if (count_r > max_count_r) begin
                max_count_r <= count_r;
            end
        end
    end

    assign words_in  = words_in_r;
    assign words_out = words_out_r;
    assign max_count = max_count_r;
`endif

endmodule
